// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants and helpers for the pipeline stage array
package pipeline_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic [DEFAULT_WIDTH-1:0] NOP = '0;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one payload register plus valid bit with load and kill controls
module pipe_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             kill,
    input  logic             next_valid,
    input  logic [WIDTH-1:0] next_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Load wins over kill so a new item entering a killed stage survives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= WIDTH'(NOP);
        end else if (load) begin
            valid <= next_valid;
            data  <= next_valid ? next_data : WIDTH'(NOP);
        end else if (kill) begin
            valid <= 1'b0;
            data  <= WIDTH'(NOP);
        end
    end

endmodule

// File: rtl/pipeline_stage_array.sv
// rtl/pipeline_stage_array.sv - DEPTH-stage valid/ready pipeline with per-stage flush
// PIPE_BUBBLE_COLLAPSE_EN selects per-stage accept (bubbles collapse) over one shared advance.
module pipeline_stage_array
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic [DEPTH-1:0]             flush_mask,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] next_valid;
    logic [WIDTH-1:0] data      [DEPTH];
    logic [WIDTH-1:0] next_data [DEPTH];

    assign live = valid & ~flush_mask;

`ifdef PIPE_BUBBLE_COLLAPSE_EN
    // A stage accepts when it is empty or being killed, or when its successor accepts.
    always_comb begin
        logic acc;
        load = '0;
        acc  = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc     = ~live[i] | acc;
            load[i] = acc;
        end
    end
`else
    logic advance;
    assign advance = ~valid[DEPTH-1] | out_ready | flush_mask[DEPTH-1];
    assign load    = {DEPTH{advance}};
`endif

    always_comb begin
        next_valid   = '0;
        next_valid[0] = in_valid;
        next_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            next_valid[i] = live[i-1];
            next_data[i]  = data[i-1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock      (clock),
            .reset      (reset),
            .load       (load[i]),
            .kill       (flush_mask[i]),
            .next_valid (next_valid[i]),
            .next_data  (next_data[i]),
            .valid      (valid[i]),
            .data       (data[i])
        );
    end

    assign in_ready  = load[0];
    assign out_valid = live[DEPTH-1];
    assign out_data  = data[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid[i]);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_array.sv
// tb/tb_pipeline_stage_array.sv - scoreboard bench for pipeline_stage_array (DEPTH=4, WIDTH=64)
module tb_pipeline_stage_array;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             in_valid   = 1'b0;
    logic [WIDTH-1:0] in_data    = '0;
    logic             out_ready  = 1'b0;
    logic [DEPTH-1:0] flush_mask = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_word;

    pipeline_stage_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush_mask (flush_mask),
        .occupancy  (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        flush_mask = '0;
        out_ready  = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (occupancy == 0) break;
            step();
        end
        check("drain_empty", 64'(occupancy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every output transfer must match the oldest expected item.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_extra: got 0x%0h expected no item", out_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("scoreboard", out_data, exp_word);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int gap;

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();

        // Streaming 0x1..0x8 with out_ready=1
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                in_data  = 64'(c + 1);
                exp_q.push_back(64'(c + 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (c >= 1 && c <= 3) check("stream_latency_idle", 64'(out_valid), 64'd0);
            if (c == 4) begin
                check("stream_first_valid", 64'(out_valid), 64'd1);
                check("stream_first_data", out_data, 64'h1);
            end
            if (c >= 4 && c <= 8) check("stream_occupancy", 64'(occupancy), 64'd4);
            step();
        end
        drain();

        // Fill 0xA..0xD under backpressure, hold, then release
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 64'hA + 64'(c);
            exp_q.push_back(64'hA + 64'(c));
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("full_out_valid", 64'(out_valid), 64'd1);
            check("full_out_data", out_data, 64'hA);
            check("full_occupancy", 64'(occupancy), 64'd4);
            step();
        end
        drain();

        // 0x12,0x11,0x10 in stages 2,1,0; kill stages 0 and 1
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 64'h12 - 64'(c);
            step();
        end
        in_valid   = 1'b0;
        flush_mask = 4'b0011;
        exp_q.push_back(64'h12);
        step();
        flush_mask = '0;
        @(negedge clock);
        check("flush_occupancy", 64'(occupancy), 64'd1);
        check("flush_out_data", out_data, 64'h12);
        step();
        @(negedge clock);
        check("flush_killed_valid", 64'(out_valid), 64'd0);
        check("flush_killed_data", out_data, 64'd0);
        step();
        @(negedge clock);
        check("flush_killed_data2", out_data, 64'd0);
        drain();

        // Accept into stage 0 while killing its old occupant
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h30;
        step();
        in_data    = 64'h31;
        flush_mask = 4'b0001;
        exp_q.push_back(64'h31);
        @(negedge clock);
        check("kill_accept_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid   = 1'b0;
        flush_mask = '0;
        @(negedge clock);
        check("kill_accept_occupancy", 64'(occupancy), 64'd1);
        drain();

        // Items in stages 3 and 0, backpressure for 3 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h20;
        exp_q.push_back(64'h20);
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 64'h21;
        exp_q.push_back(64'h21);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("bubble_occupancy_pre", 64'(occupancy), 64'd2);
        check("bubble_out_data_pre", out_data, 64'h20);
        repeat (3) step();
        @(negedge clock);
        check("bubble_occupancy_held", 64'(occupancy), 64'd2);
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        check("bubble_in_ready", 64'(in_ready), 64'd1);
`else
        check("bubble_in_ready", 64'(in_ready), 64'd0);
`endif
        step();
        out_ready = 1'b1;
        gap = 0;
        do begin
            step();
            gap++;
        end while (!out_valid && gap < 10);
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        check("bubble_gap", 64'(gap), 64'd1);
`else
        check("bubble_gap", 64'(gap), 64'd3);
`endif
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 64'h40 + 64'(c);
            step();
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("areset_occupancy_before", 64'(occupancy), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_occupancy", 64'(occupancy), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 64'h99;
        step();
        step();
        check("areset_no_capture", 64'(occupancy), 64'd0);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();
        check("areset_release_empty", 64'(occupancy), 64'd0);
        in_valid = 1'b1;
        in_data  = 64'h55;
        exp_q.push_back(64'h55);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c >= 1 && c <= 3) check("areset_latency_idle", 64'(out_valid), 64'd0);
            if (c == 4) begin
                check("areset_latency_valid", 64'(out_valid), 64'd1);
                check("areset_latency_data", out_data, 64'h55);
            end
            step();
            in_valid = 1'b0;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
